pe_result_collector: RTL and testbench

Parametrised result-path stage between an N_PE systolic PE grid and N_PORT output (CIM) memory write ports. Each PE stream is buffered in a small FIFO, so PEs never stall. PEs are grouped onto ports, and each port arbitrates its group round-robin over a valid/ready handshake. Generalises the fixed 2-PEs-per-memory wiring: any PE/port count, memory backpressure, overflow detection, per-port tile counters and an idle indication for completion logic.

---
 rtl/pe_result_collector_pkg.sv | 18 +
 rtl/pe_result_collector_if.sv | 34 +++
 rtl/pe_result_collector_result_fifo.sv | 52 +++++
 rtl/pe_result_collector.sv | 168 ++++++++++++++++
 tb/tb_pe_result_collector.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_result_collector_pkg.sv
// Shared result-path definitions: element/tile geometry, the tile type and a
// small width helper used by the collector, its interface and the bench.
package winocnn_pkg;

    localparam int RES_W     = 12;
    localparam int TILE_DIM  = 6;
    localparam int ADDR_W    = 8;
    localparam int TILE_BITS = TILE_DIM * TILE_DIM * RES_W;

    // Element [r][c] sits at bit offset (r*TILE_DIM+c)*RES_W.
    typedef logic signed [TILE_DIM-1:0][TILE_DIM-1:0][RES_W-1:0] result_tile_t;

    // Index width for a selector over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_result_collector_if.sv
// Memory-side write bus of the result collector: one valid/ready channel per
// output port, carrying tile, address and the local source PE index.
interface pe_result_collector_if #(
    parameter int N_PORT    = 2,
    parameter int TILE_BITS = winocnn_pkg::TILE_BITS,
    parameter int ADDR_W    = winocnn_pkg::ADDR_W,
    parameter int SRC_W     = 1
);

    logic [N_PORT*TILE_BITS-1:0] mem_tile_o;
    logic [N_PORT*ADDR_W-1:0]    mem_addr_o;
    logic [N_PORT*SRC_W-1:0]     mem_src_o;
    logic [N_PORT-1:0]           mem_valid_o;
    logic [N_PORT-1:0]           mem_ready_i;

    // Collector side: drives results, observes memory backpressure.
    modport master (
        output mem_tile_o,
        output mem_addr_o,
        output mem_src_o,
        output mem_valid_o,
        input  mem_ready_i
    );

    // Memory side: consumes results, drives ready.
    modport slave (
        input  mem_tile_o,
        input  mem_addr_o,
        input  mem_src_o,
        input  mem_valid_o,
        output mem_ready_i
    );

endinterface

// File: rtl/pe_result_collector_result_fifo.sv
// Small per-PE result FIFO. A push while full is still taken when a pop
// happens in the same cycle; the freed slot is exactly the one being written.
module result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("result_fifo DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit separates full (wrapped) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = store[rd_ptr[PTR_W-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents only matter between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr[PTR_W-1:0]] <= data_in;
    end

endmodule

// File: rtl/pe_result_collector.sv
// Result collector: buffers each PE result stream in its own FIFO and drains
// groups of G = N_PE/N_PORT FIFOs onto one memory write port each, with
// round-robin arbitration, a single output register per port, sticky overflow
// flags, saturating per-port transfer counters and an idle indication.
module pe_result_collector
    import winocnn_pkg::*;
#(
    parameter  int N_PE       = 4,
    parameter  int N_PORT     = 2,
    parameter  int RES_W      = winocnn_pkg::RES_W,
    parameter  int TILE_DIM   = winocnn_pkg::TILE_DIM,
    parameter  int ADDR_W     = winocnn_pkg::ADDR_W,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_W      = 16,
    localparam int TILE_BITS  = TILE_DIM * TILE_DIM * RES_W,
    localparam int G          = N_PE / N_PORT,
    localparam int SRC_W      = idx_width(G),
    localparam int ENTRY_W    = ADDR_W + TILE_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic [N_PE*TILE_BITS-1:0] pe_tile_i,
    input  logic [N_PE*ADDR_W-1:0]    pe_addr_i,
    input  logic [N_PE-1:0]           pe_valid_i,
    pe_result_collector_if.master     mem,
    output logic [N_PE-1:0]           overflow_o,
    output logic [N_PORT*CNT_W-1:0]   tile_count_o,
    output logic                      idle_o
);

    if ((N_PE % N_PORT) != 0) begin : g_bad_grouping
        $error("N_PE must be a multiple of N_PORT");
    end

    // FIFO side
    logic [ENTRY_W-1:0] fifo_head [N_PE];
    logic [N_PE-1:0]    fifo_full;
    logic [N_PE-1:0]    fifo_empty;
    logic [N_PE-1:0]    fifo_pop;
    logic [N_PE-1:0]    drop;
    logic [N_PE-1:0]    ovf_q;

    // Port side
    logic [N_PORT-1:0]                grant_vld;
    logic [N_PORT-1:0][SRC_W-1:0]     grant_idx;
    logic [N_PORT-1:0]                load;
    logic [N_PORT-1:0]                xfer;
    logic [N_PORT-1:0][SRC_W-1:0]     rr_ptr;
    logic [N_PORT-1:0]                vld_p1;
    logic [N_PORT-1:0][TILE_BITS-1:0] tile_p1;
    logic [N_PORT-1:0][ADDR_W-1:0]    addr_p1;
    logic [N_PORT-1:0][SRC_W-1:0]     src_p1;
    logic [N_PORT-1:0][CNT_W-1:0]     cnt_q;

    for (genvar i = 0; i < N_PE; i++) begin : g_pe
        result_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (pe_valid_i[i]),
            .pop     (fifo_pop[i]),
            .data_in ({pe_addr_i[i*ADDR_W +: ADDR_W], pe_tile_i[i*TILE_BITS +: TILE_BITS]}),
            .head    (fifo_head[i]),
            .full    (fifo_full[i]),
            .empty   (fifo_empty[i])
        );
    end

    // A PE result is lost only when its FIFO is full and not draining this cycle.
    assign drop = pe_valid_i & fifo_full & ~fifo_pop;

    // Round-robin grant: first non-empty FIFO from rr_ptr upward (mod G).
    // Scanning downward lets the lowest offset win by being written last.
    always_comb begin
        int li;
        grant_vld = '0;
        grant_idx = '0;
        li        = 0;
        for (int p = 0; p < N_PORT; p++) begin
            for (int k = G - 1; k >= 0; k--) begin
                li = (int'(rr_ptr[p]) + k) % G;
                if (!fifo_empty[p*G + li]) begin
                    grant_vld[p] = 1'b1;
                    grant_idx[p] = SRC_W'(li);
                end
            end
        end
    end

    // Port register loads when empty or being accepted; transfer on valid & ready.
    always_comb begin
        load = '0;
        xfer = '0;
        for (int p = 0; p < N_PORT; p++) begin
            load[p] = grant_vld[p] && (!vld_p1[p] || mem.mem_ready_i[p]);
            xfer[p] = vld_p1[p] && mem.mem_ready_i[p];
        end
    end

    // Pop the FIFO whose port is loading from it.
    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < N_PE; i++) begin
            fifo_pop[i] = load[i / G] && (grant_idx[i / G] == SRC_W'(i % G));
        end
    end

    // Output register and round-robin pointer per port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= '0;
            tile_p1 <= '0;
            addr_p1 <= '0;
            src_p1  <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int p = 0; p < N_PORT; p++) begin
                if (load[p]) begin
                    vld_p1[p]  <= 1'b1;
                    tile_p1[p] <= fifo_head[p*G + int'(grant_idx[p])][TILE_BITS-1:0];
                    addr_p1[p] <= fifo_head[p*G + int'(grant_idx[p])][ENTRY_W-1:TILE_BITS];
                    src_p1[p]  <= grant_idx[p];
                    rr_ptr[p]  <= SRC_W'((int'(grant_idx[p]) + 1) % G);
                end else if (mem.mem_ready_i[p]) begin
                    vld_p1[p]  <= 1'b0;
                end
            end
        end
    end

    // Saturating transfer counters; a transfer coinciding with clear counts as one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            for (int p = 0; p < N_PORT; p++) begin
                if (clear_i) begin
                    cnt_q[p] <= xfer[p] ? CNT_W'(1) : '0;
                end else if (xfer[p] && (cnt_q[p] != {CNT_W{1'b1}})) begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                end
            end
        end
    end

    // Sticky overflow flags; a drop coinciding with clear leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
        end else if (clear_i) begin
            ovf_q <= drop;
        end else begin
            ovf_q <= ovf_q | drop;
        end
    end

    assign mem.mem_valid_o = vld_p1;
    assign mem.mem_tile_o  = tile_p1;
    assign mem.mem_addr_o  = addr_p1;
    assign mem.mem_src_o   = src_p1;
    assign overflow_o      = ovf_q;
    assign tile_count_o    = cnt_q;
    assign idle_o          = (&fifo_empty) && !(|vld_p1);

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_pe_result_collector;
    import winocnn_pkg::*;

    localparam int N_PE   = 4;
    localparam int N_PORT = 2;
    localparam int G      = N_PE / N_PORT;
    localparam int TB     = winocnn_pkg::TILE_BITS;
    localparam int AW     = winocnn_pkg::ADDR_W;
    localparam int SW     = 1;
    localparam int FD     = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int EW     = AW + TB;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clear_i;
    logic [N_PE*TB-1:0]      pe_tile;
    logic [N_PE*AW-1:0]      pe_addr;
    logic [N_PE-1:0]         pe_valid;
    logic [N_PE-1:0]         ovf;
    logic [N_PORT*CW-1:0]    cnt;
    logic                    idle;

    pe_result_collector_if #(.N_PORT(N_PORT), .TILE_BITS(TB), .ADDR_W(AW), .SRC_W(SW)) mif ();

    pe_result_collector #(
        .N_PE(N_PE), .N_PORT(N_PORT), .FIFO_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .pe_tile_i(pe_tile), .pe_addr_i(pe_addr), .pe_valid_i(pe_valid),
        .mem(mif), .overflow_o(ovf), .tile_count_o(cnt), .idle_o(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [EW-1:0] mq [N_PE][$];
    bit            m_vld [N_PORT];
    logic [TB-1:0] m_tile [N_PORT];
    logic [AW-1:0] m_addr [N_PORT];
    int            m_src [N_PORT];
    int            m_ptr [N_PORT];
    int            m_cnt [N_PORT];
    bit            m_ovf [N_PE];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [TB-1:0] rand_tile();
        logic [TB-1:0] t;
        t = '0;
        for (int w = 0; w < (TB + 31) / 32; w++) t = {t[TB-33:0], 32'($urandom())};
        return t;
    endfunction

    task automatic put_pe(input int i, input logic [AW-1:0] a, input logic [TB-1:0] t);
        pe_valid[i]           = 1'b1;
        pe_addr[i*AW +: AW]   = a;
        pe_tile[i*TB +: TB]   = t;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_PE; i++) begin
            mq[i].delete();
            m_ovf[i] = 0;
        end
        for (int p = 0; p < N_PORT; p++) begin
            m_vld[p] = 0; m_tile[p] = '0; m_addr[p] = '0;
            m_src[p] = 0; m_ptr[p] = 0; m_cnt[p] = 0;
        end
    endtask

    // One clock edge of the specified behaviour: ports take from queues using
    // the pre-edge contents, then PE pushes land (room if not full or popped).
    task automatic model_step();
        bit popped [N_PE];
        bit found, xf, dr;
        int li, pi;
        logic [EW-1:0] e;
        for (int i = 0; i < N_PE; i++) popped[i] = 0;
        for (int p = 0; p < N_PORT; p++) begin
            xf = m_vld[p] && mif.mem_ready_i[p];
            if (clear_i) m_cnt[p] = xf ? 1 : 0;
            else if (xf && m_cnt[p] < CMAX) m_cnt[p]++;
            if (!m_vld[p] || mif.mem_ready_i[p]) begin
                found = 0;
                for (int k = 0; k < G; k++) begin
                    li = (m_ptr[p] + k) % G;
                    pi = p * G + li;
                    if (!found && mq[pi].size() != 0) begin
                        e = mq[pi].pop_front();
                        m_tile[p] = e[TB-1:0];
                        m_addr[p] = e[EW-1:TB];
                        m_src[p]  = li;
                        m_ptr[p]  = (li + 1) % G;
                        popped[pi] = 1;
                        found = 1;
                    end
                end
                m_vld[p] = found;
            end
        end
        for (int i = 0; i < N_PE; i++) begin
            dr = 0;
            if (pe_valid[i]) begin
                if ((mq[i].size() + int'(popped[i])) < FD || popped[i])
                    mq[i].push_back({pe_addr[i*AW +: AW], pe_tile[i*TB +: TB]});
                else
                    dr = 1;
            end
            if (clear_i) m_ovf[i] = dr;
            else if (dr) m_ovf[i] = 1;
        end
    endtask

    task automatic compare_all();
        logic [N_PORT-1:0] ev;
        logic [N_PE-1:0]   eo;
        bit                ei;
        ei = 1;
        for (int i = 0; i < N_PE; i++) begin
            eo[i] = m_ovf[i];
            if (mq[i].size() != 0) ei = 0;
        end
        for (int p = 0; p < N_PORT; p++) begin
            ev[p] = m_vld[p];
            if (m_vld[p]) ei = 0;
        end
        chk("valid", 512'(mif.mem_valid_o), 512'(ev));
        chk("overflow", 512'(ovf), 512'(eo));
        chk("idle", 512'(idle), 512'(ei));
        for (int p = 0; p < N_PORT; p++) begin
            chk($sformatf("count%0d", p), 512'(cnt[p*CW +: CW]), 512'(m_cnt[p]));
            if (m_vld[p]) begin
                chk($sformatf("addr%0d", p), 512'(mif.mem_addr_o[p*AW +: AW]), 512'(m_addr[p]));
                chk($sformatf("src%0d", p), 512'(mif.mem_src_o[p*SW +: SW]), 512'(m_src[p]));
                chk($sformatf("tile%0d", p), 512'(mif.mem_tile_o[p*TB +: TB]), 512'(m_tile[p]));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        pe_valid = '0;
        clear_i  = 1'b0;
    endtask

    logic [TB-1:0] bt [8];
    result_tile_t  rt;

    initial begin
        reset = 1'b0; clear_i = 1'b0; pe_valid = '0; pe_tile = '0; pe_addr = '0;
        mif.mem_ready_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", 512'(mif.mem_valid_o), 512'(0));
        chk("rst_idle", 512'(idle), 512'(1));
        chk("rst_count", 512'(cnt), 512'(0));
        chk("rst_ovf", 512'(ovf), 512'(0));
        chk("rst_tile", 512'(mif.mem_tile_o), 512'(0));

        // Single result through port 0
        mif.mem_ready_i = '1;
        bt[0] = '0; bt[0][RES_W-1:0] = 12'hFFB;
        put_pe(0, 8'h12, bt[0]);
        cycle();
        chk("single_lat", 512'(mif.mem_valid_o[0]), 512'(0));
        cycle();
        chk("single_vld", 512'(mif.mem_valid_o[0]), 512'(1));
        chk("single_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h12));
        chk("single_src", 512'(mif.mem_src_o[0]), 512'(0));
        rt = mif.mem_tile_o[0 +: TB];
        chk("single_elem", 512'(rt[0][0]), 512'(12'hFFB));
        cycle();
        chk("single_cnt", 512'(cnt[0 +: CW]), 512'(1));
        chk("single_idle", 512'(idle), 512'(1));

        // Round-robin: pointer sits at 1 after granting PE0
        put_pe(0, 8'h20, rand_tile()); put_pe(1, 8'h21, rand_tile());
        cycle(); cycle();
        chk("rr1_src", 512'(mif.mem_src_o[0]), 512'(1));
        chk("rr1_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h21));
        cycle();
        chk("rr2_src", 512'(mif.mem_src_o[0]), 512'(0));
        chk("rr2_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h20));
        cycle();
        put_pe(1, 8'h22, rand_tile());
        cycle(); cycle(); cycle();
        put_pe(0, 8'h23, rand_tile()); put_pe(1, 8'h24, rand_tile());
        cycle(); cycle();
        chk("rr3_src", 512'(mif.mem_src_o[0]), 512'(0));
        cycle();
        chk("rr4_src", 512'(mif.mem_src_o[0]), 512'(1));
        cycle();

        // Backpressure and overflow on PE0
        mif.mem_ready_i = 2'b10;
        for (int n = 0; n < 6; n++) begin
            bt[n] = rand_tile();
            put_pe(0, AW'(8'h30 + n), bt[n]);
            cycle();
            if (n == 4) chk("bp_no_ovf", 512'(ovf[0]), 512'(0));
        end
        chk("bp_ovf", 512'(ovf[0]), 512'(1));
        for (int n = 0; n < 2; n++) begin
            cycle();
            chk("bp_stable_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h30));
            chk("bp_stable_tile", 512'(mif.mem_tile_o[0 +: TB]), 512'(bt[0]));
        end
        mif.mem_ready_i = 2'b11;
        for (int n = 0; n < 5; n++) begin
            chk("bp_drain_vld", 512'(mif.mem_valid_o[0]), 512'(1));
            chk("bp_drain_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h30 + n));
            chk("bp_drain_tile", 512'(mif.mem_tile_o[0 +: TB]), 512'(bt[n]));
            cycle();
        end
        chk("bp_empty", 512'(mif.mem_valid_o[0]), 512'(0));
        clear_i = 1'b1;
        cycle();
        chk("clr_ovf", 512'(ovf[0]), 512'(0));

        // Push into a full FIFO while it is popped
        mif.mem_ready_i = 2'b10;
        for (int n = 0; n < 5; n++) begin
            put_pe(0, AW'(8'h40 + n), rand_tile());
            cycle();
        end
        mif.mem_ready_i = 2'b11;
        put_pe(0, 8'h45, rand_tile());
        cycle();
        chk("fp_no_ovf", 512'(ovf[0]), 512'(0));
        for (int n = 1; n < 6; n++) begin
            chk("fp_addr", 512'(mif.mem_addr_o[0 +: AW]), 512'(8'h40 + n));
            cycle();
        end
        chk("fp_done", 512'(mif.mem_valid_o[0]), 512'(0));

        // Both ports in parallel
        bt[6] = rand_tile();
        put_pe(2, 8'h52, bt[6]); put_pe(0, 8'h50, rand_tile());
        cycle(); cycle();
        chk("par_vld", 512'(mif.mem_valid_o), 512'(2'b11));
        chk("par_src1", 512'(mif.mem_src_o[SW +: SW]), 512'(0));
        chk("par_addr1", 512'(mif.mem_addr_o[AW +: AW]), 512'(8'h52));
        chk("par_tile1", 512'(mif.mem_tile_o[TB +: TB]), 512'(bt[6]));
        cycle();

        // Clear together with a transfer
        put_pe(0, 8'h60, rand_tile());
        cycle(); cycle();
        clear_i = 1'b1;
        cycle();
        chk("clr_xfer_cnt", 512'(cnt[0 +: CW]), 512'(1));

        // Asynchronous reset in the middle of traffic
        mif.mem_ready_i = 2'b00;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < N_PE; i++) put_pe(i, AW'($urandom()), rand_tile());
            cycle();
        end
        pe_valid = '1;
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 512'(mif.mem_valid_o), 512'(0));
        chk("arst_idle", 512'(idle), 512'(1));
        chk("arst_tile", 512'(mif.mem_tile_o), 512'(0));
        chk("arst_addr", 512'(mif.mem_addr_o), 512'(0));
        chk("arst_ovf", 512'(ovf), 512'(0));
        chk("arst_cnt", 512'(cnt), 512'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        pe_valid = '0;
        reset = 1'b1;

        // Randomized traffic with stall phases, clears and counter saturation
        for (int c = 0; c < 1500; c++) begin
            int mode;
            mode = (c / 60) % 3;
            for (int i = 0; i < N_PE; i++)
                if ($urandom_range(99) < 40) put_pe(i, AW'($urandom()), rand_tile());
            for (int p = 0; p < N_PORT; p++)
                mif.mem_ready_i[p] = (mode == 0) ? ($urandom_range(99) < 70)
                                   : (mode == 1) ? ($urandom_range(99) < 15) : 1'b1;
            clear_i = ($urandom_range(99) < 3);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
